// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int MIN_DIV = 4;
  localparam int DIV_W = 32;
  typedef logic [DIV_W-1:0] div_t;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a selectable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial receiver with a runtime-programmable bit period
module uart_byte_rx #(
  parameter int DIV_W = 32,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ser_rx,
  input  logic [DIV_W-1:0]     cfg_divider,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err
);
  import uart_pkg::*;
  localparam int IDX_W = $clog2(DATA_BITS);
  logic rx_s;
  state_t state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, d, d_n, d_in, d_last, h_last;
  logic [IDX_W-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n, data_n;
  logic valid_n, ferr_n;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .resetn(resetn), .d(ser_rx), .q(rx_s));

  assign d_in = (cfg_divider < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_divider;
  assign d_last = d - DIV_W'(1);
  assign h_last = (d >> 1) - DIV_W'(1);

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      d <= DIV_W'(MIN_DIV);
      idx <= '0;
      sh <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      d <= d_n;
      idx <= idx_n;
      sh <= sh_n;
      data <= data_n;
      valid <= valid_n;
      frame_err <= ferr_n;
    end

  // The divider is frozen at start detection so cfg changes never disturb a frame in flight.
  always_comb begin
    state_n = state;
    cnt_n = cnt + DIV_W'(1);
    d_n = d;
    idx_n = idx;
    sh_n = sh;
    data_n = data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        d_n = rx_s ? d : d_in;
        state_n = rx_s ? IDLE : START;
      end
      START: if (cnt == h_last) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == d_last) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[DATA_BITS-1:1]};
        idx_n = idx + IDX_W'(1);
        state_n = (idx == IDX_W'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (cnt == d_last) begin
        cnt_n = '0;
        data_n = rx_s ? sh : data;
        valid_n = rx_s;
        ferr_n = !rx_s;
        state_n = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for uart_byte_rx with directed frames
module tb_uart_byte_rx;
  typedef struct {
    bit ferr;
    logic [7:0] data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ser_rx = 1'b1;
  logic [31:0] cfg_divider = 32'd217;
  logic [7:0] data;
  logic valid, frame_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] last_data = 8'h00;
  exp_t q[$];

  uart_byte_rx #(.DIV_W(32), .DATA_BITS(8)) dut (
    .clk(clk),
    .resetn(resetn),
    .ser_rx(ser_rx),
    .cfg_divider(cfg_divider),
    .data(data),
    .valid(valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int deff();
    return (cfg_divider < 32'd4) ? 4 : int'(cfg_divider);
  endfunction

  // Called at a negedge; the next posedge is where the first sync flop sees the start bit.
  task automatic send(input logic [7:0] b, input bit good);
    int d, t0;
    logic [9:0] f;
    exp_t e;
    d = deff();
    t0 = cyc + 1;
    f = {good, b, 1'b0};
    e.ferr = !good;
    e.data = good ? b : last_data;
    e.cyc = t0 + 2 + d / 2 + 9 * d;
    q.push_back(e);
    if (good) last_data = b;
    for (int i = 0; i < 10; i++) begin
      ser_rx = f[i];
      repeat (d) @(negedge clk);
    end
    if (!good) repeat (2 * d) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  always @(negedge clk) begin
    if (resetn && (valid || frame_err)) begin
      if (valid && frame_err) begin
        check("strobes_exclusive", 1, 0, 0);
      end else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=0x%02h at cycle %0d, expected no strobe",
                 valid, frame_err, data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe_kind_frame_err", frame_err, e.ferr, 0);
        check("data", data, e.data, 0);
        check("strobe_cycle", cyc, e.cyc, 1);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", valid, 0, 0);
    check("reset_frame_err", frame_err, 0, 0);
    check("reset_data", data, 0, 0);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h41, 1'b1);
    repeat (300) @(negedge clk);
    send(8'h48, 1'b1);
    send(8'h69, 1'b1);
    send(8'h0D, 1'b1);
    send(8'h0A, 1'b1);
    repeat (300) @(negedge clk);
    ser_rx = 1'b0;
    repeat (50) @(negedge clk);
    ser_rx = 1'b1;
    repeat (400) @(negedge clk);
    send(8'h55, 1'b1);
    repeat (300) @(negedge clk);
    send(8'hA5, 1'b0);
    repeat (300) @(negedge clk);
    send(8'h3C, 1'b1);
    repeat (300) @(negedge clk);
    // Start of 0xFF, interrupted by reset in the middle of data bit 4.
    ser_rx = 1'b0;
    repeat (217) @(negedge clk);
    ser_rx = 1'b1;
    repeat (4 * 217 + 108) @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_valid", valid, 0, 0);
    check("midreset_frame_err", frame_err, 0, 0);
    check("midreset_data", data, 0, 0);
    last_data = 8'h00;
    resetn = 1'b1;
    repeat (6 * 217) @(negedge clk);
    send(8'h12, 1'b1);
    repeat (300) @(negedge clk);
    cfg_divider = 32'd3;
    send(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    cfg_divider = 32'd5;
    send(8'hFF, 1'b1);
    repeat (100) @(negedge clk);
    check("scoreboard_pending", q.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
